// File: rtl/freq_entry_ctrl_if.sv
// Button / display bundle for the BCD frequency-entry controller.
// master drives the buttons (front panel), slave is the controller itself.
interface freq_entry_ctrl_if #(
  parameter int unsigned DIGITS = 5
);
  logic                  btn_up;
  logic                  btn_down;
  logic                  btn_left;
  logic                  btn_right;
  logic                  btn_enter;
  logic [4*DIGITS-1:0]   bcd;
  logic [2:0]            cursor;
  logic [31:0]           bin;
  logic                  bin_valid;
  logic                  clamped;
  logic                  busy;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_enter,
    input  bcd, cursor, bin, bin_valid, clamped, busy
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_enter,
    output bcd, cursor, bin, bin_valid, clamped, busy
  );
endinterface

// File: rtl/freq_entry_ctrl.sv
// BCD digit editor with cursor, plus a serial BCD-to-binary converter that
// commits the buffer on ENTER and clamps the result to MAX_VAL.
module freq_entry_ctrl #(
  parameter int unsigned          DIGITS    = 5,
  parameter logic [4*DIGITS-1:0]  RESET_BCD = 20'h01000,
  parameter logic [31:0]          MAX_VAL   = 32'd99999
) (
  input  logic clk,
  input  logic reset,
  freq_entry_ctrl_if.slave bus
);

  typedef enum logic {EDIT, CONV} state_t;

  state_t               state_q, state_d;
  logic [4*DIGITS-1:0]  bcd_q;
  logic [2:0]           cursor_q;
  logic [31:0]          bin_q;
  logic                 vld_p0;
  logic                 clamped_q;
  logic [31:0]          acc_q;
  logic [3:0]           cnt_q;
  logic [4*DIGITS-1:0]  snap_q;

  logic                 do_enter, do_up, do_down, do_left, do_right;
  logic                 do_step, do_done;
  logic [3:0]           sel_digit;
  logic [3:0]           msd;
  logic [31:0]          acc_next;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  function automatic logic [31:0] sat_max(input logic [31:0] x);
    return (x > MAX_VAL) ? MAX_VAL : x;
  endfunction

  function automatic logic [2:0] cur_left(input logic [2:0] c);
    return (c == 3'(DIGITS - 1)) ? 3'd0 : c + 3'd1;
  endfunction

  function automatic logic [2:0] cur_right(input logic [2:0] c);
    return (c == 3'd0) ? 3'(DIGITS - 1) : c - 3'd1;
  endfunction

  assign sel_digit = bcd_q[{cursor_q, 2'b00} +: 4];
  assign msd       = snap_q[4*DIGITS-1 -: 4];
  // acc*10 built from two shifts so no multiplier is inferred
  assign acc_next  = (acc_q << 3) + (acc_q << 1) + {28'd0, msd};

  always_comb begin
    state_d  = state_q;
    do_enter = 1'b0;
    do_up    = 1'b0;
    do_down  = 1'b0;
    do_left  = 1'b0;
    do_right = 1'b0;
    do_step  = 1'b0;
    do_done  = 1'b0;
    case (state_q)
      EDIT: begin
        if (bus.btn_enter) begin
          do_enter = 1'b1;
          state_d  = CONV;
        end else if (bus.btn_up) begin
          do_up = 1'b1;
        end else if (bus.btn_down) begin
          do_down = 1'b1;
        end else if (bus.btn_left) begin
          do_left = 1'b1;
        end else if (bus.btn_right) begin
          do_right = 1'b1;
        end
      end
      CONV: begin
        do_step = 1'b1;
        if (cnt_q == 4'(DIGITS - 1)) begin
          do_done = 1'b1;
          state_d = EDIT;
        end
      end
      default: state_d = EDIT;
    endcase
  end

  // edit / convert stage: all state advances here on the rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EDIT;
      bcd_q     <= RESET_BCD;
      cursor_q  <= 3'd0;
      bin_q     <= 32'd0;
      vld_p0    <= 1'b0;
      clamped_q <= 1'b0;
      acc_q     <= 32'd0;
      cnt_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      vld_p0  <= do_done;
      if (do_up)
        bcd_q[{cursor_q, 2'b00} +: 4] <= bcd_inc(sel_digit);
      if (do_down)
        bcd_q[{cursor_q, 2'b00} +: 4] <= bcd_dec(sel_digit);
      if (do_left)
        cursor_q <= cur_left(cursor_q);
      if (do_right)
        cursor_q <= cur_right(cursor_q);
      if (do_enter) begin
        acc_q <= 32'd0;
        cnt_q <= 4'd0;
      end
      if (do_step) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + 4'd1;
      end
      if (do_done) begin
        bin_q     <= sat_max(acc_next);
        clamped_q <= (acc_next > MAX_VAL);
      end
    end
  end

  // the snapshot only carries data; it is always reloaded before use
  always_ff @(posedge clk) begin
    if (do_enter)
      snap_q <= bcd_q;
    else if (do_step)
      snap_q <= snap_q << 4;
  end

  assign bus.bcd       = bcd_q;
  assign bus.cursor    = cursor_q;
  assign bus.bin       = bin_q;
  assign bus.bin_valid = vld_p0;
  assign bus.clamped   = clamped_q;
  assign bus.busy      = (state_q == CONV);

endmodule

// File: tb/tb_freq_entry_ctrl.sv
// Bench for freq_entry_ctrl: directed steps plus random button traffic,
// every cycle compared against a digit-array reference model.
module tb_freq_entry_ctrl;
  localparam int ND   = 5;
  localparam int MAXV = 50000;

  localparam logic [4:0] B_ENTER = 5'b10000;
  localparam logic [4:0] B_UP    = 5'b01000;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_LEFT  = 5'b00010;
  localparam logic [4:0] B_RIGHT = 5'b00001;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   failures = 0;

  freq_entry_ctrl_if #(.DIGITS(ND)) bus ();

  freq_entry_ctrl #(
    .DIGITS(ND),
    .RESET_BCD(20'h01000),
    .MAX_VAL(32'd50000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int m_d[ND];
  int m_cur;
  int m_bin;
  int m_clamp;
  int m_valid;
  int m_busy;
  int m_snap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_value();
    int v = 0;
    int p = 1;
    for (int i = 0; i < ND; i++) begin
      v += m_d[i] * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_bcd();
    logic [31:0] r = 32'd0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'(m_d[i]);
    return r;
  endfunction

  task automatic model_reset();
    logic [19:0] rb = 20'h01000;
    for (int i = 0; i < ND; i++) m_d[i] = int'(rb[4*i +: 4]);
    m_cur = 0; m_bin = 0; m_clamp = 0; m_valid = 0; m_busy = 0;
  endtask

  task automatic model_edge(input logic [4:0] b, input logic r);
    if (r) begin
      model_reset();
    end else begin
      m_valid = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_bin   = (m_snap > MAXV) ? MAXV : m_snap;
          m_clamp = (m_snap > MAXV) ? 1 : 0;
          m_valid = 1;
        end
      end else if (b[4]) begin
        m_snap = model_value();
        m_busy = ND;
      end else if (b[3]) begin
        m_d[m_cur] = (m_d[m_cur] + 1) % 10;
      end else if (b[2]) begin
        m_d[m_cur] = (m_d[m_cur] + 9) % 10;
      end else if (b[1]) begin
        m_cur = (m_cur + 1) % ND;
      end else if (b[0]) begin
        m_cur = (m_cur + ND - 1) % ND;
      end
    end
  endtask

  task automatic check_all();
    chk("bcd", 32'(bus.bcd), model_bcd());
    chk("cursor", 32'(bus.cursor), 32'(m_cur));
    chk("bin", bus.bin, 32'(m_bin));
    chk("bin_valid", 32'(bus.bin_valid), 32'(m_valid));
    chk("clamped", 32'(bus.clamped), 32'(m_clamp));
    chk("busy", 32'(bus.busy), (m_busy > 0) ? 32'd1 : 32'd0);
  endtask

  // one clock: drive buttons, let the edge sample them, then compare
  task automatic cyc(input logic [4:0] b, input logic r = 1'b0);
    bus.btn_enter = b[4];
    bus.btn_up    = b[3];
    bus.btn_down  = b[2];
    bus.btn_left  = b[1];
    bus.btn_right = b[0];
    reset = r;
    @(posedge clk);
    #1;
    bus.btn_enter = 1'b0;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    reset = 1'b0;
    model_edge(b, r);
    check_all();
  endtask

  task automatic set_buffer(input int val);
    int t[ND];
    int v = val;
    for (int i = 0; i < ND; i++) begin
      t[i] = v % 10;
      v = v / 10;
    end
    for (int pos = 0; pos < ND; pos++) begin
      while (m_cur != pos) cyc(B_LEFT);
      while (m_d[pos] != t[pos]) cyc(B_UP);
    end
  endtask

  initial begin
    int pulses;
    logic [31:0] bcd_before;
    logic [31:0] tmp;
    logic [4:0] b;
    int v;

    reset = 1'b1;
    bus.btn_enter = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    model_reset();

    // reset overriding simultaneous buttons
    cyc(5'b11111, 1'b1);
    cyc(5'b11111, 1'b1);
    chk("rst_bcd", 32'(bus.bcd), 32'h01000);
    chk("rst_cursor", 32'(bus.cursor), 32'd0);
    chk("rst_bin", bus.bin, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_clamped", 32'(bus.clamped), 32'd0);

    // first commit: busy cycles 1..5, result in cycle 6
    cyc(B_ENTER);
    for (int i = 1; i < ND; i++) begin
      chk("conv_busy", 32'(bus.busy), 32'd1);
      chk("conv_novalid", 32'(bus.bin_valid), 32'd0);
      cyc(5'b0);
    end
    chk("conv_busy5", 32'(bus.busy), 32'd1);
    cyc(5'b0);
    chk("c6_bin", bus.bin, 32'd1000);
    chk("c6_valid", 32'(bus.bin_valid), 32'd1);
    chk("c6_clamped", 32'(bus.clamped), 32'd0);
    chk("c6_busy", 32'(bus.busy), 32'd0);
    cyc(5'b0);
    chk("c7_valid", 32'(bus.bin_valid), 32'd0);
    chk("c7_bin_hold", bus.bin, 32'd1000);

    // digit wrap up/down
    repeat (9) cyc(B_UP);
    tmp = 32'(bus.bcd);
    chk("d0_is9", {28'd0, tmp[3:0]}, 32'd9);
    cyc(B_UP);
    tmp = 32'(bus.bcd);
    chk("wrap_up_d0", {28'd0, tmp[3:0]}, 32'd0);
    chk("wrap_up_d1", {28'd0, tmp[7:4]}, 32'd0);
    chk("wrap_up_d3", {28'd0, tmp[15:12]}, 32'd1);
    cyc(B_DOWN);
    tmp = 32'(bus.bcd);
    chk("wrap_dn_d0", {28'd0, tmp[3:0]}, 32'd9);

    // cursor wrap and priority
    cyc(B_RIGHT);
    chk("right_wrap", 32'(bus.cursor), 32'd4);
    cyc(B_LEFT);
    chk("left_wrap", 32'(bus.cursor), 32'd0);
    cyc(B_UP | B_LEFT);
    tmp = 32'(bus.bcd);
    chk("prio_cursor", 32'(bus.cursor), 32'd0);
    chk("prio_d0", {28'd0, tmp[3:0]}, 32'd0);
    cyc(B_DOWN | B_RIGHT | B_LEFT);
    chk("prio_dn_cursor", 32'(bus.cursor), 32'd0);

    // clamp then unclamped commit
    set_buffer(98765);
    chk("buf_98765", 32'(bus.bcd), 32'h98765);
    cyc(B_ENTER);
    repeat (ND) cyc(5'b0);
    chk("clamp_bin", bus.bin, 32'd50000);
    chk("clamp_flag", 32'(bus.clamped), 32'd1);
    set_buffer(42);
    chk("clamp_held", 32'(bus.clamped), 32'd1);
    cyc(B_ENTER);
    repeat (ND) cyc(5'b0);
    chk("bin_42", bus.bin, 32'd42);
    chk("unclamp_flag", 32'(bus.clamped), 32'd0);

    // buttons ignored during conversion
    set_buffer(12345);
    bcd_before = 32'(bus.bcd);
    pulses = 0;
    cyc(B_ENTER);
    for (int i = 0; i < ND; i++) begin
      cyc((i % 2 == 0) ? B_UP : (B_ENTER | B_UP));
      pulses += int'(bus.bin_valid);
    end
    for (int i = 0; i < ND; i++) begin
      cyc(5'b0);
      pulses += int'(bus.bin_valid);
    end
    chk("conv_bcd_hold", 32'(bus.bcd), bcd_before);
    chk("conv_pulses", 32'(pulses), 32'd1);
    chk("conv_bin", bus.bin, 32'd12345);

    // reset in the third conversion cycle
    cyc(B_ENTER);
    cyc(5'b0);
    cyc(5'b0);
    cyc(5'b0, 1'b1);
    chk("abort_valid", 32'(bus.bin_valid), 32'd0);
    chk("abort_bin", bus.bin, 32'd0);
    chk("abort_bcd", 32'(bus.bcd), 32'h01000);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    pulses = 0;
    repeat (ND + 2) begin
      cyc(5'b0);
      pulses += int'(bus.bin_valid);
    end
    chk("abort_nopulse", 32'(pulses), 32'd0);

    // random commits of arbitrary values
    repeat (6) begin
      v = int'($urandom_range(0, 99999));
      set_buffer(v);
      cyc(B_ENTER);
      repeat (ND) cyc(5'b0);
      chk("rnd_commit", bus.bin, (v > MAXV) ? 32'(MAXV) : 32'(v));
    end

    // random button traffic, occasional reset
    repeat (1500) begin
      v = int'($urandom_range(0, 99));
      if (v < 35) b = 5'b0;
      else if (v < 80) b = 5'(1 << $urandom_range(0, 3));
      else if (v < 88) b = B_ENTER;
      else b = 5'($urandom_range(0, 31));
      cyc(b, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
